// File: rtl/chip8_vga_scanout.sv
// CHIP-8 64x32 framebuffer scanout to 640x480@60 VGA, 10x10 pixel scaling.
// Ports: clk/reset (sync, active-high); fb_read_address/fb_read_enable out,
// fb_read_data in (1-clk RAM latency); hsync/vsync (active-low), video_on,
// pixel, frame_start (all 3 clks behind the counters); vblank (undelayed).
// Build option: CHIP8_SCANOUT_BORDER_EN draws separator lines just above
// and just below the image band.
module chip8_vga_scanout #(
  parameter logic [11:0] SCREEN_RAM_OFFSET = 12'h100,
  parameter int          V_IMAGE_START     = 80
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] fb_read_address,
  output logic        fb_read_enable,
  input  logic [7:0]  fb_read_data,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pixel,
  output logic        vblank,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST  = 10'd799;
  localparam logic [9:0] V_LAST  = 10'd524;
  localparam logic [9:0] V_TOP   = 10'(V_IMAGE_START);
  localparam logic [9:0] V_BOT   = 10'(V_IMAGE_START + 320);
  localparam logic [9:0] V_ABOVE = 10'(V_IMAGE_START - 1);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic [3:0] xs_q, xs_d, ys_q, ys_d;
  logic [5:0] px_x_q, px_x_d;
  logic [4:0] px_y_q, px_y_d;

  always_comb begin
    h_d    = h_q + 10'd1;
    v_d    = v_q;
    xs_d   = xs_q + 4'd1;
    px_x_d = px_x_q;
    ys_d   = ys_q;
    px_y_d = px_y_q;
    if (xs_q == 4'd9) begin
      xs_d   = 4'd0;
      px_x_d = px_x_q + 6'd1;
    end
    if (h_q == H_LAST) begin
      h_d    = 10'd0;
      xs_d   = 4'd0;
      px_x_d = 6'd0;
      v_d    = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      // Realign the row scaler exactly at the first band line.
      if (v_d == V_TOP) begin
        ys_d   = 4'd0;
        px_y_d = 5'd0;
      end else if (ys_q == 4'd9) begin
        ys_d   = 4'd0;
        px_y_d = px_y_q + 5'd1;
      end else begin
        ys_d = ys_q + 4'd1;
      end
    end
  end

  logic h_vis, in_band, border_c;
  logic hs_c, vs_c, von_c, fs_c;

  assign h_vis   = h_q < 10'd640;
  assign in_band = h_vis && (v_q >= V_TOP) && (v_q < V_BOT);
  assign hs_c    = !((h_q >= 10'd656) && (h_q < 10'd752));
  assign vs_c    = !((v_q == 10'd490) || (v_q == 10'd491));
  assign von_c   = h_vis && (v_q < 10'd480);
  assign fs_c    = (h_q == 10'd0) && (v_q == 10'd0);
  assign vblank  = v_q >= 10'd480;

`ifdef CHIP8_SCANOUT_BORDER_EN
  assign border_c = h_vis && ((v_q == V_ABOVE) || (v_q == V_BOT));
`else
  assign border_c = 1'b0;
`endif

  logic [2:0] bit1_q, bit2_q;
  logic       band1_q, band2_q, brd1_q, brd2_q;
  logic       hs1_q, hs2_q, vs1_q, vs2_q;
  logic       von1_q, von2_q, fs1_q, fs2_q;
  logic       pix_d;

  assign pix_d = (band2_q & fb_read_data[bit2_q]) | brd2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q             <= '0;
      v_q             <= '0;
      xs_q            <= '0;
      ys_q            <= '0;
      px_x_q          <= '0;
      px_y_q          <= '0;
      fb_read_address <= '0;
      fb_read_enable  <= 1'b0;
      bit1_q          <= '0;
      bit2_q          <= '0;
      band1_q         <= 1'b0;
      band2_q         <= 1'b0;
      brd1_q          <= 1'b0;
      brd2_q          <= 1'b0;
      hs1_q           <= 1'b1;
      hs2_q           <= 1'b1;
      vs1_q           <= 1'b1;
      vs2_q           <= 1'b1;
      von1_q          <= 1'b0;
      von2_q          <= 1'b0;
      fs1_q           <= 1'b0;
      fs2_q           <= 1'b0;
      hsync           <= 1'b1;
      vsync           <= 1'b1;
      video_on        <= 1'b0;
      frame_start     <= 1'b0;
      pixel           <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      xs_q   <= xs_d;
      ys_q   <= ys_d;
      px_x_q <= px_x_d;
      px_y_q <= px_y_d;
      // Stage 1: fetch the byte holding this pixel.
      fb_read_enable  <= in_band;
      fb_read_address <= in_band
        ? SCREEN_RAM_OFFSET + {4'd0, px_y_q, 3'd0}
          + {9'd0, px_x_q[5:3]}
        : 12'd0;
      bit1_q  <= 3'd7 - px_x_q[2:0];
      band1_q <= in_band;
      brd1_q  <= border_c;
      hs1_q   <= hs_c;
      vs1_q   <= vs_c;
      von1_q  <= von_c;
      fs1_q   <= fs_c;
      // Stage 2: wait out the RAM read.
      bit2_q  <= bit1_q;
      band2_q <= band1_q;
      brd2_q  <= brd1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      von2_q  <= von1_q;
      fs2_q   <= fs1_q;
      // Stage 3: pick the bit, align the timing signals.
      pixel       <= pix_d;
      hsync       <= hs2_q;
      vsync       <= vs2_q;
      video_on    <= von2_q;
      frame_start <= fs2_q;
    end
  end

endmodule

// File: tb/tb_chip8_vga_scanout.sv
// Self-checking bench for chip8_vga_scanout: per-cycle comparison against
// a position-based reference model, plus a table of fetch/pixel vectors.
module tb_chip8_vga_scanout;

  localparam int V   = 4;
  localparam int OFF = 'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] fb_read_address;
  logic        fb_read_enable;
  logic [7:0]  fb_read_data;
  logic        hsync, vsync, video_on, pixel, vblank, frame_start;

  logic [7:0] mem [4096];

  always #5 clk = ~clk;

  chip8_vga_scanout #(
    .SCREEN_RAM_OFFSET(12'h100),
    .V_IMAGE_START(V)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fb_read_address(fb_read_address),
    .fb_read_enable(fb_read_enable),
    .fb_read_data(fb_read_data),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .pixel(pixel),
    .vblank(vblank),
    .frame_start(frame_start)
  );

  always @(posedge clk) fb_read_data <= mem[fb_read_address];

  int k;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] addr;
    logic        en;
    logic        pix;
  } vec_t;

  vec_t tbl [13];

  function automatic bit m_band(int p);
    int h = p % 800;
    int v = p / 800;
    return (h < 640) && (v >= V) && (v < V + 320);
  endfunction

  function automatic int m_addr(int p);
    int h = p % 800;
    int v = p / 800;
    if (!m_band(p)) return 0;
    return OFF + ((v - V) / 10) * 8 + (h / 10) / 8;
  endfunction

  function automatic logic m_pix(int p);
    int h = p % 800;
    int v = p / 800;
    logic [7:0] b;
    if (m_band(p)) begin
      b = mem[m_addr(p)];
      return b[7 - ((h / 10) % 8)];
    end
`ifdef CHIP8_SCANOUT_BORDER_EN
    return (h < 640) && ((v == V - 1) || (v == V + 320));
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d actual=%0h required=%0h", nm, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) k = 0;
    else k++;
    @(negedge clk);
  endtask

  task automatic check_all();
    int p, h, v;
    if (k >= 3) begin
      p = k - 3;
      h = p % 800;
      v = p / 800;
      chk("hsync", hsync, !(h >= 656 && h < 752));
      chk("vsync", vsync, !(v == 490 || v == 491));
      chk("video_on", video_on, (h < 640) && (v < 480));
      chk("frame_start", frame_start, p == 0);
      chk("pixel", pixel, m_pix(p));
    end else begin
      chk("hsync_rst", hsync, 1);
      chk("vsync_rst", vsync, 1);
      chk("video_on_rst", video_on, 0);
      chk("frame_start_rst", frame_start, 0);
      chk("pixel_rst", pixel, 0);
    end
    if (k >= 1) begin
      chk("fb_addr", fb_read_address, m_addr(k - 1));
      chk("fb_en", fb_read_enable, m_band(k - 1));
    end else begin
      chk("fb_addr_rst", fb_read_address, 0);
      chk("fb_en_rst", fb_read_enable, 0);
    end
    chk("vblank", vblank, (k / 800) >= 480);
  endtask

  int hs_low;
  int p;

  initial begin
    tbl[0]  = '{0,   3,  12'h000, 1'b0, 1'b0};
    tbl[1]  = '{0,   4,  12'h100, 1'b1, 1'b1};
    tbl[2]  = '{9,   4,  12'h100, 1'b1, 1'b1};
    tbl[3]  = '{10,  4,  12'h100, 1'b1, 1'b0};
    tbl[4]  = '{80,  4,  12'h101, 1'b1, 1'b0};
    tbl[5]  = '{639, 4,  12'h107, 1'b1, 1'b0};
    tbl[6]  = '{640, 4,  12'h000, 1'b0, 1'b0};
    tbl[7]  = '{0,   13, 12'h100, 1'b1, 1'b1};
    tbl[8]  = '{0,   14, 12'h108, 1'b1, 1'b0};
    tbl[9]  = '{629, 14, 12'h10F, 1'b1, 1'b0};
    tbl[10] = '{630, 14, 12'h10F, 1'b1, 1'b1};
    tbl[11] = '{639, 23, 12'h10F, 1'b1, 1'b1};
    tbl[12] = '{639, 24, 12'h117, 1'b1, 1'b0};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem['h100] = 8'h80;
    mem['h10F] = 8'h01;

    reset = 1'b1;
    k = 0;
    repeat (3) begin
      tick();
      check_all();
    end
    reset = 1'b0;

    while (k < 25 * 800) begin
      tick();
      check_all();
      for (int i = 0; i < 13; i++) begin
        p = tbl[i].v * 800 + tbl[i].h;
        if (k == p + 1) begin
          chk($sformatf("tbl%0d_addr", i), fb_read_address, tbl[i].addr);
          chk($sformatf("tbl%0d_en", i), fb_read_enable, tbl[i].en);
        end
        if (k == p + 3)
          chk($sformatf("tbl%0d_pix", i), pixel, tbl[i].pix);
      end
    end

    reset = 1'b1;
    repeat (2) begin
      tick();
      check_all();
    end
    for (int i = 'h100; i < 'h200; i++) mem[i] = 8'($urandom);
    reset = 1'b0;

    hs_low = 0;
    while (k < 20 * 800 + 300) begin
      tick();
      check_all();
      if (k >= 3 && k < 3 + 20 * 800 && hsync == 1'b0) hs_low++;
    end
    chk("hsync_low_count", hs_low, 20 * 96);

    reset = 1'b1;
    repeat (5) begin
      tick();
      check_all();
    end
    reset = 1'b0;

    repeat (2 * 800) begin
      tick();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_vga_scanout.md
CHIP8_VGA_SCANOUT -- requirements
Module: chip8_vga_scanout

Interface
REQ-001 SHALL have parameter SCREEN_RAM_OFFSET, default 12'h100, giving the byte address of framebuffer byte 0 (64x32, 8 bytes/row, MSB = leftmost pixel).
REQ-002 SHALL have parameter V_IMAGE_START, default 80, giving the first visible line of the 320-line image band.
REQ-003 SHALL have port clk, input, 1, pixel clock (25.175 MHz nominal); all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port fb_read_address, output, 12, registered framebuffer read address.
REQ-006 SHALL have port fb_read_enable, output, 1, registered read strobe.
REQ-007 SHALL have port fb_read_data, input, 8, RAM data, valid 1 clk after the address/enable register.
REQ-008 SHALL have ports hsync and vsync, output, 1 each, active-low sync.
REQ-009 SHALL have port video_on, output, 1, high in the 640x480 visible area.
REQ-010 SHALL have port pixel, output, 1, monochrome pixel value.
REQ-011 SHALL have port vblank, output, 1, high for v_count >= 480 (undelayed counter domain).
REQ-012 SHALL have port frame_start, output, 1, one-clk pulse aligned with the pixel at (0,0).

Function
REQ-013 SHALL run h_count 0..799 (visible 0-639, front porch 640-655, sync 656-751, back porch 752-799) and v_count 0..524 (visible 0-479, front porch 480-489, sync 490-491, back porch 492-524); v_count increments when h_count wraps 799->0, and wraps 524->0.
REQ-014 SHALL scale 10x10: x_sub 0..9/px_x 0..63 track h_count; y_sub 0..9/px_y 0..31 track v_count within the band; no dividers.
REQ-015 SHALL treat the image band as V_IMAGE_START <= v_count < V_IMAGE_START+320, h_count < 640.
REQ-016 Stage 1: in the band, SHALL register fb_read_address = SCREEN_RAM_OFFSET + px_y*8 + px_x[5:3] and fb_read_enable = 1; outside the band, enable = 0 and address = 0.
REQ-017 Stage 2: SHALL carry bit index 7-px_x[2:0] and an in-band flag alongside the RAM latency.
REQ-018 Stage 3: SHALL register pixel = fb_read_data[bit index] when in-band, else 0.
REQ-019 hsync, vsync, video_on and frame_start SHALL be delayed 3 clks so that all outputs align with pixel; total latency from counters to outputs is 3 clks.
REQ-020 SHALL never write memory; framebuffer changes made by the sprite engine mid-frame appear in the next fetched byte with no tearing protection.
REQ-021 At each counter wrap the sub-counters SHALL reset exactly: x_sub/px_x to 0 at h_count 0; y_sub/px_y to 0 at v_count = V_IMAGE_START.

Reset
REQ-022 While reset is high, SHALL clear h_count, v_count, sub-counters and pipeline, and drive hsync=1, vsync=1, video_on=0, pixel=0, vblank=0, frame_start=0, fb_read_enable=0, fb_read_address=0.
REQ-023 Reset asserted mid-frame SHALL restart at (0,0) on the first clk after release; the first frame_start pulse is output 3 clks after release.

Configuration
REQ-024 When CHIP8_SCANOUT_BORDER_EN is defined, pixel SHALL be 1 for visible pixels on lines V_IMAGE_START-1 and V_IMAGE_START+320 (separator rules), with the same 3-clk latency.
REQ-025 When CHIP8_SCANOUT_BORDER_EN is undefined, pixel SHALL be 0 everywhere outside the image band.

Verification
REQ-026 Reset, then count clks -> hsync low exactly 96 clks per 800-clk line; vsync low exactly 2 lines per 525-line frame; frame_start period 420000 clks.
REQ-027 RAM model holds 0x80 at 0x100, zeros elsewhere -> pixel=1 only for output columns 0-9 on lines 80-89.
REQ-028 RAM holds 0x01 at 0x1FF -> pixel=1 only at columns 630-639 on lines 390-399; fb_read_address never exceeds 0x1FF.
REQ-029 Line 80, h_count 0 -> fb_read_address=0x100 and enable=1 one clk later; h_count 80 -> 0x101; pixel for column 0 appears 3 clks after h_count=0.
REQ-030 Assert reset at v_count=200, h_count=300 for 5 clks -> outputs match REQ-022 during reset, and the counters restart at (0,0) after release.
REQ-031 Build with and without CHIP8_SCANOUT_BORDER_EN, all-zero RAM -> lines 79 and 400 are all-ones vs. all-zeros; all other lines are zero in both builds.
